// File: rtl/alu_share_arbiter.sv
// Two-requester front end for one shared combinational ALU. Round-robin grant,
// registered operands toward the ALU, and a held response until the consumer accepts.
module alu_share_arbiter #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [2*N-1:0] req_srcA,
  input  logic [2*N-1:0] req_srcB,
  input  logic [5:0]     req_op,
  output logic [N-1:0]   alu_srcA,
  output logic [N-1:0]   alu_srcB,
  output logic [2:0]     alu_opCode,
  input  logic [N-1:0]   alu_result,
  input  logic           alu_zero,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [N-1:0]   rsp_result,
  output logic           rsp_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t         state_q, state_d;
  logic           prio_q;
  logic           id_q;
  logic [N-1:0]   srca_q, srcb_q;
  logic [2:0]     op_q;
  logic [N-1:0]   result_q;
  logic           zero_q;
  logic           gnt_s;
  logic           accept_s;

  // A lone requester wins outright; the pointer only breaks ties.
  assign gnt_s    = (req_valid == 2'b11) ? prio_q : req_valid[1];
  assign accept_s = (state_q == IDLE) && (req_valid != 2'b00);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid != 2'b00) begin
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs; req_ready is masked by rst so no grant shows during reset
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rst && (req_valid != 2'b00)) begin
          req_ready = gnt_s ? 2'b10 : 2'b01;
        end else begin
          req_ready = 2'b00;
        end
      end
      EXEC: rsp_valid = 1'b0;
      RESP: rsp_valid = 1'b1;
      default: begin
        req_ready = 2'b00;
        rsp_valid = 1'b0;
      end
    endcase
  end

  // Operand capture on accept, result capture at the end of EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q   <= 1'b0;
      id_q     <= 1'b0;
      srca_q   <= '0;
      srcb_q   <= '0;
      op_q     <= 3'b000;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      if (accept_s) begin
        id_q   <= gnt_s;
        prio_q <= ~gnt_s;
        srca_q <= gnt_s ? req_srcA[2*N-1:N] : req_srcA[N-1:0];
        srcb_q <= gnt_s ? req_srcB[2*N-1:N] : req_srcB[N-1:0];
        op_q   <= gnt_s ? req_op[5:3] : req_op[2:0];
      end
      if (state_q == EXEC) begin
        result_q <= alu_result;
        zero_q   <= alu_zero;
      end
    end
  end

  assign alu_srcA   = srca_q;
  assign alu_srcB   = srcb_q;
  assign alu_opCode = op_q;
  assign rsp_id     = id_q;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU attached.
module tb_alu_share_arbiter;
  localparam int N = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*N-1:0] req_srcA, req_srcB;
  logic [5:0]     req_op;
  logic [N-1:0]   alu_srcA, alu_srcB, alu_result;
  logic [2:0]     alu_opCode;
  logic           alu_zero;
  logic           rsp_valid, rsp_ready, rsp_id, rsp_zero;
  logic [N-1:0]   rsp_result;

  int n_checks = 0;
  int n_pass   = 0;

  alu_share_arbiter #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_srcA(req_srcA), .req_srcB(req_srcB), .req_op(req_op),
    .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_opCode(alu_opCode),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero)
  );

  always #5 clk = ~clk;

  // Shared ALU: add, sub, and, or, signed less-than; other codes give 0
  always_comb begin
    case (alu_opCode)
      3'b000:  alu_result = alu_srcA + alu_srcB;
      3'b001:  alu_result = alu_srcA - alu_srcB;
      3'b010:  alu_result = alu_srcA & alu_srcB;
      3'b011:  alu_result = alu_srcA | alu_srcB;
      3'b101:  alu_result = ($signed(alu_srcA) < $signed(alu_srcB)) ? 32'd1 : 32'd0;
      default: alu_result = 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 2'b00;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_rsp(input string tag);
    for (int c = 0; c < 8; c++) begin
      if (rsp_valid) return;
      tick();
    end
    check({tag, "_timeout"}, 64'(rsp_valid), 64'd1);
  endtask

  // One complete transaction with an always-ready consumer
  task automatic do_op(input string tag, input int id, input logic [N-1:0] a,
                       input logic [N-1:0] b, input logic [2:0] op,
                       input logic [N-1:0] exp_res, input logic exp_zero);
    req_srcA[id*N +: N] = a;
    req_srcB[id*N +: N] = b;
    req_op[id*3 +: 3]   = op;
    req_valid = (id == 1) ? 2'b10 : 2'b01;
    rsp_ready = 1'b1;
    #1;
    check({tag, "_ready"}, 64'(req_ready), (id == 1) ? 64'd2 : 64'd1);
    tick();
    req_valid = 2'b00;
    #1;
    check({tag, "_exec_rv"}, 64'(rsp_valid), 64'd0);
    tick();
    check({tag, "_rv"}, 64'(rsp_valid), 64'd1);
    check({tag, "_id"}, 64'(rsp_id), 64'(id));
    check({tag, "_res"}, 64'(rsp_result), 64'(exp_res));
    check({tag, "_zero"}, 64'(rsp_zero), 64'(exp_zero));
    tick();
    check({tag, "_done_rv"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    logic [N-1:0] held;
    rst = 1'b1;
    req_valid = 2'b11;
    req_srcA = '0;
    req_srcB = '0;
    req_op = 6'd0;
    rsp_ready = 1'b1;
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    tick();
    tick();
    check("rst_ready2", 64'(req_ready), 64'd0);
    check("rst_rv", 64'(rsp_valid), 64'd0);
    check("rst_srcA", 64'(alu_srcA), 64'd0);
    check("rst_op", 64'(alu_opCode), 64'd0);

    // Single op: 7 - 5
    do_reset();
    do_op("single", 0, 32'd7, 32'd5, 3'b001, 32'd2, 1'b0);

    // Contention: grants alternate starting with requester 0
    rst = 1'b1;
    tick();
    req_srcA = {32'hFFFF_FFFF, 32'd3};
    req_srcB = {32'd1, 32'd4};
    req_op   = {3'b101, 3'b000};
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    rst = 1'b0;
    #1;
    check("cont_first_ready", 64'(req_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      wait_rsp("cont");
      check("cont_id", 64'(rsp_id), 64'(k % 2));
      check("cont_res", 64'(rsp_result), (k % 2 == 1) ? 64'd1 : 64'd7);
    end
    tick();

    // Backpressure: response held for 5 cycles with both requesters waiting
    do_reset();
    req_srcA[N-1:0] = 32'd10;
    req_srcB[N-1:0] = 32'd3;
    req_op[2:0] = 3'b001;
    req_valid = 2'b01;
    rsp_ready = 1'b0;
    tick();
    req_valid = 2'b11;
    tick();
    for (int c = 0; c < 5; c++) begin
      check("bp_rv", 64'(rsp_valid), 64'd1);
      check("bp_res", 64'(rsp_result), 64'd7);
      check("bp_ready", 64'(req_ready), 64'd0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_rv_last", 64'(rsp_valid), 64'd1);
    tick();
    check("bp_after_rv", 64'(rsp_valid), 64'd0);
    check("bp_resume", 64'(req_ready), 64'd2);
    req_valid = 2'b00;
    tick();
    tick();
    tick();

    // Zero flag, including an undefined opcode
    do_reset();
    do_op("zero_sub", 0, 32'h1234_5678, 32'h1234_5678, 3'b001, 32'd0, 1'b1);
    do_op("zero_111", 1, 32'h1234_5678, 32'h1234_5678, 3'b111, 32'd0, 1'b1);

    // Idle stability: operands from the last op stay on the ALU port
    held = 32'h1234_5678;
    req_valid = 2'b00;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("idle_ready", 64'(req_ready), 64'd0);
      check("idle_rv", 64'(rsp_valid), 64'd0);
      check("idle_srcA", 64'(alu_srcA), 64'(held));
      check("idle_op", 64'(alu_opCode), 64'd7);
    end

    // Reset while in EXEC discards the op
    req_srcA = {32'd9, 32'd9};
    req_srcB = {32'd1, 32'd1};
    req_op   = 6'd0;
    req_valid = 2'b10;
    rsp_ready = 1'b1;
    tick();
    rst = 1'b1;
    req_valid = 2'b11;
    #1;
    check("rexec_ready_in_rst", 64'(req_ready), 64'd0);
    tick();
    check("rexec_ready_rst2", 64'(req_ready), 64'd0);
    check("rexec_rv", 64'(rsp_valid), 64'd0);
    check("rexec_srcA", 64'(alu_srcA), 64'd0);
    rst = 1'b0;
    #1;
    check("rexec_first_grant", 64'(req_ready), 64'd1);
    req_valid = 2'b00;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("rexec_no_rsp", 64'(rsp_valid), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
